// File: rtl/cheat_pkg.sv
// rtl/cheat_pkg.sv - shared constants and sequencer state type for the cheat program path
package cheat_pkg;

   localparam int CHEAT_SLOTS   = 6;
   localparam int PGM_IDX_MASK  = 6;
   localparam int PGM_IDX_FLAGS = 7;

   // flag bit positions; set bits live at [5:0], matching clear bits at [13:8]
   localparam int FLAG_CHEAT   = 0;
   localparam int FLAG_NMI     = 1;
   localparam int FLAG_IRQ     = 2;
   localparam int FLAG_HOLDOFF = 3;
   localparam int FLAG_BUTTONS = 4;
   localparam int FLAG_WRAM    = 5;
   localparam int FLAG_CLR_OFS = 8;

   // bits of the flags word that actually carry a set or clear request
   localparam logic [31:0] FLAGS_ACTIVE = 32'h0000_3F3F;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_DISABLE,
      SEQ_SLOTS,
      SEQ_MASK,
      SEQ_FLAGS,
      SEQ_DONE
   } seq_state_t;

endpackage

// File: rtl/cheat_dirty_prio.sv
// rtl/cheat_dirty_prio.sv - lowest-set-bit priority encoder for the dirty slot vector
module cheat_dirty_prio #(
   parameter int N     = 6,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // scan from the top down so the lowest set bit wins
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cheat_pgm_sequencer.sv
// rtl/cheat_pgm_sequencer.sv - stages cheat slots/mask/flags and replays them as an ordered program burst
module cheat_pgm_sequencer
   import cheat_pkg::*;
#(
   parameter int NUM_SLOTS = CHEAT_SLOTS,
   parameter int IDX_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [31:0]      cfg_data,
   input  logic             cfg_commit,
   input  logic             snescmd_unlock,
   input  logic             snescmd_wr_strobe,
   input  logic             cheat_hit,
   output logic [IDX_W-1:0] pgm_idx,
   output logic [31:0]      pgm_in,
   output logic             pgm_we,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [IDX_W-1:0] IDX_MASK   = IDX_W'(NUM_SLOTS);
   localparam logic [IDX_W-1:0] IDX_FLAGS  = IDX_W'(NUM_SLOTS + 1);
   localparam logic [3:0]       ADDR_MASK  = 4'(NUM_SLOTS);
   localparam logic [3:0]       ADDR_FLAGS = 4'(NUM_SLOTS + 1);

   seq_state_t           state, state_nxt;
   logic [31:0]          slot_shadow [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] mask_shadow;
   logic [31:0]          flags_shadow;
   logic [NUM_SLOTS-1:0] dirty;
   logic                 mask_dirty;
   logic                 dis_done;
   logic                 issue_pending, pend_nxt;
   logic [IDX_W-1:0]     idx_r, ld_idx;
   logic [31:0]          in_r, ld_data;
   logic                 err_r;

   logic                 blocked, we;
   logic                 idle_like, stage_we, stage_slot, stage_mask, stage_flags;
   logic                 commit_ok, reject, flags_live, flags_live_staged, work_now;
   logic [NUM_SLOTS-1:0] slot_clear, slot_set, dirty_left;
   logic [IDX_W-1:0]     prio_idx;
   logic                 prio_valid, mask_need;
   seq_state_t           sel_state;
   logic [IDX_W-1:0]     sel_idx;
   logic [31:0]          sel_data;

   assign blocked   = (snescmd_unlock & snescmd_wr_strobe) | cheat_hit;
   assign we        = issue_pending & ~blocked & ~rst;
   assign idle_like = (state == SEQ_IDLE) || (state == SEQ_DONE);

   assign stage_we    = cfg_we & idle_like;
   assign stage_slot  = stage_we && (cfg_addr < ADDR_MASK);
   assign stage_mask  = stage_we && (cfg_addr == ADDR_MASK);
   assign stage_flags = stage_we && (cfg_addr == ADDR_FLAGS);
   assign commit_ok   = cfg_commit & idle_like;
   assign reject      = (cfg_we | cfg_commit) & ~idle_like;

   assign flags_live        = |(flags_shadow & FLAGS_ACTIVE);
   assign flags_live_staged = stage_flags ? |(cfg_data & FLAGS_ACTIVE) : flags_live;
   assign work_now          = (|dirty) | mask_dirty | stage_slot | stage_mask | flags_live_staged;

   // decode which slot bit a staging write sets and which bit an accepted slot write clears
   always_comb begin
      slot_set   = '0;
      slot_clear = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (stage_we && cfg_addr == 4'(i))
            slot_set[i] = 1'b1;
         if (state == SEQ_SLOTS && we && idx_r == IDX_W'(i))
            slot_clear[i] = 1'b1;
      end
   end

   assign dirty_left = dirty & ~slot_clear;
   assign mask_need  = mask_dirty | dis_done | (state == SEQ_DISABLE && we);

   cheat_dirty_prio #(
      .N     (NUM_SLOTS),
      .IDX_W (IDX_W)
   ) u_prio (
      .req   (dirty_left),
      .idx   (prio_idx),
      .valid (prio_valid)
   );

   // look ahead past the disable step: next dirty slot, else mask, else flags, else finish
   always_comb begin
      sel_state = SEQ_DONE;
      sel_idx   = '0;
      sel_data  = '0;
      if (prio_valid) begin
         sel_state = SEQ_SLOTS;
         sel_idx   = prio_idx;
         sel_data  = slot_shadow[prio_idx];
      end else if (mask_need) begin
         sel_state = SEQ_MASK;
         sel_idx   = IDX_MASK;
         sel_data  = 32'(mask_shadow);
      end else if (flags_live) begin
         sel_state = SEQ_FLAGS;
         sel_idx   = IDX_FLAGS;
         sel_data  = flags_shadow;
      end
   end

   // next state and the program word to present next; words change only on accepted writes
   always_comb begin
      state_nxt = state;
      pend_nxt  = issue_pending;
      ld_idx    = idx_r;
      ld_data   = in_r;
      unique case (state)
         SEQ_IDLE, SEQ_DONE: begin
            state_nxt = SEQ_IDLE;
            pend_nxt  = 1'b0;
            if (commit_ok)
               state_nxt = work_now ? SEQ_DISABLE : SEQ_DONE;
         end
         SEQ_DISABLE: begin
            if (!issue_pending) begin
               if (|dirty) begin
                  pend_nxt = 1'b1;
                  ld_idx   = IDX_MASK;
                  ld_data  = '0;
               end else begin
                  state_nxt = sel_state;
                  pend_nxt  = (sel_state != SEQ_DONE);
                  ld_idx    = sel_idx;
                  ld_data   = sel_data;
               end
            end else if (we) begin
               state_nxt = sel_state;
               pend_nxt  = (sel_state != SEQ_DONE);
               ld_idx    = sel_idx;
               ld_data   = sel_data;
            end
         end
         SEQ_SLOTS: begin
            if (we) begin
               state_nxt = sel_state;
               pend_nxt  = (sel_state != SEQ_DONE);
               ld_idx    = sel_idx;
               ld_data   = sel_data;
            end
         end
         SEQ_MASK: begin
            if (we) begin
               state_nxt = flags_live ? SEQ_FLAGS : SEQ_DONE;
               pend_nxt  = flags_live;
               if (flags_live) begin
                  ld_idx  = IDX_FLAGS;
                  ld_data = flags_shadow;
               end
            end
         end
         SEQ_FLAGS: begin
            if (we) begin
               state_nxt = SEQ_DONE;
               pend_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = SEQ_IDLE;
            pend_nxt  = 1'b0;
         end
      endcase
   end

   // state, staged shadows and bookkeeping; reset also drops all staged work
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SEQ_IDLE;
         issue_pending <= 1'b0;
         idx_r         <= '0;
         in_r          <= '0;
         for (int i = 0; i < NUM_SLOTS; i++)
            slot_shadow[i] <= '0;
         mask_shadow   <= '0;
         flags_shadow  <= '0;
         dirty         <= '0;
         mask_dirty    <= 1'b0;
         dis_done      <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         state         <= state_nxt;
         issue_pending <= pend_nxt;
         idx_r         <= ld_idx;
         in_r          <= ld_data;
         dirty         <= (dirty | slot_set) & ~slot_clear;
         for (int i = 0; i < NUM_SLOTS; i++)
            if (slot_set[i])
               slot_shadow[i] <= cfg_data;
         if (stage_mask) begin
            mask_shadow <= cfg_data[NUM_SLOTS-1:0];
            mask_dirty  <= 1'b1;
         end else if (state == SEQ_MASK && we) begin
            mask_dirty  <= 1'b0;
         end
         if (stage_flags)
            flags_shadow <= cfg_data;
         else if (state == SEQ_FLAGS && we)
            flags_shadow <= '0;
         if (commit_ok)
            dis_done <= 1'b0;
         else if (state == SEQ_DISABLE && we)
            dis_done <= 1'b1;
         if (reject)
            err_r <= 1'b1;
         else if (commit_ok)
            err_r <= 1'b0;
      end
   end

   assign pgm_idx = idx_r;
   assign pgm_in  = in_r;
   assign pgm_we  = we;
   assign busy    = !idle_like;
   assign done    = (state == SEQ_DONE);
   assign err     = err_r;

endmodule

// File: tb/tb_cheat_pgm_sequencer.sv
// tb/tb_cheat_pgm_sequencer.sv - directed self-checking bench for cheat_pgm_sequencer
module tb_cheat_pgm_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic        cfg_commit = 1'b0;
   logic        snescmd_unlock = 1'b0;
   logic        snescmd_wr_strobe = 1'b0;
   logic        cheat_hit = 1'b0;
   logic [2:0]  pgm_idx;
   logic [31:0] pgm_in;
   logic        pgm_we;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int failures = 0;

   logic [31:0] wr_idx_q [$];
   logic [31:0] wr_dat_q [$];
   int busy_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int last_done_cyc = 0;
   int base_n, base_busy, base_done;

   cheat_pgm_sequencer #(.NUM_SLOTS(6), .IDX_W(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_we            (cfg_we),
      .cfg_addr          (cfg_addr),
      .cfg_data          (cfg_data),
      .cfg_commit        (cfg_commit),
      .snescmd_unlock    (snescmd_unlock),
      .snescmd_wr_strobe (snescmd_wr_strobe),
      .cheat_hit         (cheat_hit),
      .pgm_idx           (pgm_idx),
      .pgm_in            (pgm_in),
      .pgm_we            (pgm_we),
      .busy              (busy),
      .done              (done),
      .err               (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (pgm_we) begin
         wr_idx_q.push_back(32'(pgm_idx));
         wr_dat_q.push_back(pgm_in);
         last_we_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mark_log();
      base_n    = wr_idx_q.size();
      base_busy = busy_cnt;
      base_done = done_cnt;
   endtask

   function automatic logic [31:0] log_idx(input int i);
      return (base_n + i < wr_idx_q.size()) ? wr_idx_q[base_n + i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] log_dat(input int i);
      return (base_n + i < wr_dat_q.size()) ? wr_dat_q[base_n + i] : 32'hDEAD_BEEF;
   endfunction

   task automatic stage(input logic [3:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick(1);
      cfg_we = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick(1);
      cfg_commit = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int start;
      int k;
      start = done_cnt;
      for (k = 0; k < 60 && done_cnt == start; k++) tick(1);
      if (done_cnt == start) check_eq(tag, 32'd0, 32'd1);
   endtask

   task automatic expect_writes(input string tag, input int n,
                                input logic [31:0] ei [4], input logic [31:0] ed [4]);
      check_eq({tag, "_cnt"}, 32'(wr_idx_q.size() - base_n), 32'(n));
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("%s_idx%0d", tag, i), log_idx(i), ei[i]);
         check_eq($sformatf("%s_dat%0d", tag, i), log_dat(i), ed[i]);
      end
   endtask

   // wait for the given index to be presented, then block it for n cycles
   task automatic block_at(input string tag, input int use_snes, input logic [2:0] idx, input int n);
      int found;
      int we_seen;
      int idx_bad;
      found = 0; we_seen = 0; idx_bad = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         if (busy && pgm_idx == idx) found = 1;
         else tick(1);
      end
      if (found == 0) begin
         check_eq({tag, "_reach"}, 32'd0, 32'd1);
      end else begin
         if (use_snes != 0) begin
            snescmd_unlock = 1'b1; snescmd_wr_strobe = 1'b1;
         end else begin
            cheat_hit = 1'b1;
         end
         repeat (n) begin
            @(negedge clk);
            if (pgm_we) we_seen++;
            if (pgm_idx !== idx) idx_bad++;
            tick(1);
         end
         snescmd_unlock = 1'b0; snescmd_wr_strobe = 1'b0; cheat_hit = 1'b0;
         check_eq({tag, "_we_low"}, 32'(we_seen), 32'd0);
         check_eq({tag, "_idx_held"}, 32'(idx_bad), 32'd0);
         @(negedge clk);
         check_eq({tag, "_release_we"}, {31'd0, pgm_we}, 32'd1);
         check_eq({tag, "_release_idx"}, 32'(pgm_idx), 32'(idx));
      end
   endtask

   logic [31:0] ei [4];
   logic [31:0] ed [4];

   initial begin
      // reset state
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_we",   {31'd0, pgm_we}, 32'd0);
      check_eq("rst_idx",  32'(pgm_idx), 32'd0);
      check_eq("rst_in",   pgm_in, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_err",  {31'd0, err}, 32'd0);
      tick(1);

      // one slot plus mask, unblocked
      stage(4'd0, 32'h7E0DBE09);
      stage(4'd6, 32'h0000_0001);
      mark_log();
      commit();
      wait_done("t1_timeout");
      ei = '{32'd6, 32'd0, 32'd6, 32'd0};
      ed = '{32'h0, 32'h7E0DBE09, 32'h1, 32'h0};
      expect_writes("t1", 3, ei, ed);
      check_eq("t1_busy_cycles", 32'(busy_cnt - base_busy), 32'd4);
      check_eq("t1_done_pulses", 32'(done_cnt - base_done), 32'd1);
      check_eq("t1_done_lat", 32'(last_done_cyc - last_we_cyc), 32'd1);
      tick(2);

      // slots 1 and 4, slot-4 write held off by cheat_hit; mask shadow still holds 1
      stage(4'd1, 32'h1111_2201);
      stage(4'd4, 32'h4444_5504);
      mark_log();
      commit();
      block_at("t2", 0, 3'd4, 5);
      wait_done("t2_timeout");
      ei = '{32'd6, 32'd1, 32'd4, 32'd6};
      ed = '{32'h0, 32'h1111_2201, 32'h4444_5504, 32'h1};
      expect_writes("t2", 4, ei, ed);
      tick(2);

      // flags only, held off by the snescmd write window
      stage(4'd7, 32'h0000_0300);
      mark_log();
      commit();
      block_at("t3", 1, 3'd7, 2);
      wait_done("t3_timeout");
      ei = '{32'd7, 32'd0, 32'd0, 32'd0};
      ed = '{32'h300, 32'h0, 32'h0, 32'h0};
      expect_writes("t3", 1, ei, ed);
      tick(2);
      mark_log();
      commit();
      wait_done("t3b_timeout");
      check_eq("t3_flags_cleared_cnt", 32'(wr_idx_q.size() - base_n), 32'd0);
      check_eq("t3_flags_cleared_busy", 32'(busy_cnt - base_busy), 32'd0);
      tick(2);

      // staging during a burst is rejected and flagged
      stage(4'd3, 32'hCCCC_0003);
      mark_log();
      commit();
      stage(4'd3, 32'hDDDD_0003);
      check_eq("t4_err_set", {31'd0, err}, 32'd1);
      wait_done("t4_timeout");
      ei = '{32'd6, 32'd3, 32'd6, 32'd0};
      ed = '{32'h0, 32'hCCCC_0003, 32'h1, 32'h0};
      expect_writes("t4", 3, ei, ed);
      check_eq("t4_err_sticky", {31'd0, err}, 32'd1);
      tick(2);
      mark_log();
      commit();
      @(negedge clk);
      check_eq("t4_idle_done", {31'd0, done}, 32'd1);
      check_eq("t4_idle_busy", {31'd0, busy}, 32'd0);
      check_eq("t4_err_clear", {31'd0, err}, 32'd0);
      tick(2);
      check_eq("t4_idle_writes", 32'(wr_idx_q.size() - base_n), 32'd0);

      // reset in the middle of the slot scan
      stage(4'd0, 32'hA0A0_0000);
      stage(4'd1, 32'hA1A1_0001);
      stage(4'd2, 32'hA2A2_0002);
      commit();
      begin
         int found;
         found = 0;
         for (int k = 0; k < 40 && found == 0; k++) begin
            if (busy && pgm_idx == 3'd1) found = 1;
            else tick(1);
         end
         check_eq("t5_reach", 32'(found), 32'd1);
      end
      rst = 1'b1;
      @(negedge clk);
      check_eq("t5_we_in_rst", {31'd0, pgm_we}, 32'd0);
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("t5_we_after", {31'd0, pgm_we}, 32'd0);
      check_eq("t5_busy_after", {31'd0, busy}, 32'd0);
      tick(1);
      mark_log();
      commit();
      wait_done("t5_timeout");
      check_eq("t5_fresh_writes", 32'(wr_idx_q.size() - base_n), 32'd0);
      tick(2);

      // stage and commit in the same cycle
      mark_log();
      cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 32'hEEEE_0002; cfg_commit = 1'b1;
      tick(1);
      cfg_we = 1'b0; cfg_commit = 1'b0;
      wait_done("t6_timeout");
      ei = '{32'd6, 32'd2, 32'd6, 32'd0};
      ed = '{32'h0, 32'hEEEE_0002, 32'h0, 32'h0};
      expect_writes("t6", 3, ei, ed);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
